conv_column_streamer: RTL
=========================

Name: conv_column_streamer

Overview:
- Parametrised successor of the layer-0 column feeder: fetches image columns from feature-map RAM and streams them, one column per handshake, to a parallel conv array.
- Adds multi-channel traversal, zero padding, stride-aware window flags and ready/valid backpressure on the output.
- Performs no arithmetic on pixel values; the MAC units downstream own the kernels.

Parameters:
- DATA_WIDTH, 16: pixel width (FP16 bit pattern, passed through untouched).
- BUS_WIDTH, 256: RAM read-word width; PPW = BUS_WIDTH/DATA_WIDTH pixels per word.
- IMAGE_SIZE, 28: square input height/width.
- KERNEL_SIZE, 5: window width used for window flags.
- STRIDE, 1: column stride, 1 or 2.
- PADDING, 0: zero rows/columns added on each side, 0..2.
- NUM_CHANNELS, 1: input channels, stored channel-major.
- ADDR_WIDTH, 12: RAM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  word address of channel 0, column 0; latched on start.
- rd_en  out  1  RAM read strobe.
- addr  out  ADDR_WIDTH  RAM word address.
- data_in  in  BUS_WIDTH  RAM read data, valid exactly 1 cycle after rd_en.
- col_data  out  (IMAGE_SIZE+2*PADDING)*DATA_WIDTH  padded column; row r at bits [r*DATA_WIDTH +: DATA_WIDTH].
- col_valid  out  1  col_data valid.
- col_ready  in  1  consumer accepts when col_valid&&col_ready.
- col_channel  out  $clog2(NUM_CHANNELS)+1  channel of current column.
- col_idx  out  $clog2(IMAGE_SIZE+2*PADDING)+1  padded column index.
- win_valid  out  1  a complete, stride-aligned window ends at this column.
- out_col_num  out  $clog2(IMAGE_SIZE)+1  output column index when win_valid.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Derived values:
  - WPC = ceil(IMAGE_SIZE/PPW) words per column.
  - PW = IMAGE_SIZE + 2*PADDING, the padded column count.
  - OW = (PW - KERNEL_SIZE)/STRIDE + 1, output columns per channel.
- Reset:
  - State IDLE; all counters 0.
  - rd_en, col_valid, win_valid, busy and done are 0.
  - col_data, addr, col_channel, col_idx and out_col_num are 0.
  - Reset mid-frame aborts immediately: no done pulse, no further reads.
- FSM states: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - On start, latch base_addr, set ch=0, c=0.
  - Go to EMIT with a zero column if c < PADDING; otherwise go to FETCH.
- FETCH:
  - rd_en is high for WPC consecutive cycles, words w = 0..WPC-1.
  - addr = base + (ch*IMAGE_SIZE + (c-PADDING))*WPC + w.
  - Word w, captured 1 cycle later, fills rows PADDING + w*PPW + j for j < PPW where w*PPW + j < IMAGE_SIZE. Excess lanes are dropped.
  - Top and bottom PADDING rows are zero.
  - Enter EMIT on the cycle after the last capture. Fetch latency per column is WPC+1 cycles.
- Padding columns (c < PADDING or c >= PADDING + IMAGE_SIZE): no reads, all-zero col_data, direct entry to EMIT.
- EMIT:
  - col_valid=1. col_data, col_channel, col_idx, win_valid and out_col_num stay stable until accepted.
  - win_valid = (c >= KERNEL_SIZE-1) && ((c-(KERNEL_SIZE-1)) % STRIDE == 0).
  - out_col_num = (c-(KERNEL_SIZE-1))/STRIDE while win_valid; 0 otherwise.
  - On accept: c++. If c wraps past PW-1, set c=0 and ch++.
  - Then go to FETCH or EMIT (padding column) for the next column, or to DONE if ch reaches NUM_CHANNELS.
  - col_valid drops the cycle after accept unless the next column is a padding column, in which case back-to-back valid is allowed.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- col_ready is ignored while col_valid=0.
- Throughput at col_ready=1: one column per WPC+2 cycles for data columns and one per cycle for padding columns.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is flagged.

Test Plan:
- Basic frame:
  - Setup: defaults; RAM pixel(col,row) = col*32 + row; base 0; col_ready=1.
  - Expect: 28 columns with addr sequence 0,1,2,3,…,55 and column 3 row 20 = 0x0074.
  - Expect: win_valid first on col_idx 4 with out_col_num 0, last on col_idx 27 with out_col_num 23; one done pulse.
- Padding and stride:
  - Setup: PADDING=2, STRIDE=2.
  - Expect: col_idx 0,1,30,31 all zero with no rd_en; rows 0,1,30,31 zero in every column.
  - Expect: win_valid on col_idx 4,6,…,30 with out_col_num 0..13 (OW=14).
- Backpressure:
  - Stimulus: hold col_ready=0 for 10 cycles on col_idx 7.
  - Expect: col_data stable, no rd_en during the stall; the column is accepted once and col_idx 8 follows.
- Multi-channel:
  - Setup: NUM_CHANNELS=3, base 0x100.
  - Expect: channel 1, col 0 reads addr 0x100+56; col_channel steps 0→1→2; 84 accepts total; done asserted once.
- Reset and start filtering:
  - Stimulus: assert rst during FETCH of column 10.
  - Expect: next cycle rd_en=0, col_valid=0, busy=0, and no done pulse.
  - Stimulus: pulse start while busy.
  - Expect: ignored; the frame completes normally.

Source files
------------

// File: rtl/conv_column_streamer_if.sv
`default_nettype none
// Streamer bus bundle: feature-map RAM read port, frame control and the column stream handshake.
interface conv_column_streamer_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int BUS_WIDTH    = 256,
  parameter int IMAGE_SIZE   = 28,
  parameter int PADDING      = 0,
  parameter int NUM_CHANNELS = 1,
  parameter int ADDR_WIDTH   = 12
);
  localparam int PW    = IMAGE_SIZE + 2 * PADDING;
  localparam int COL_W = PW * DATA_WIDTH;
  localparam int CH_W  = $clog2(NUM_CHANNELS) + 1;
  localparam int IDX_W = $clog2(PW) + 1;
  localparam int OCN_W = $clog2(IMAGE_SIZE) + 1;

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BUS_WIDTH-1:0]  data_in;
  logic [COL_W-1:0]      col_data;
  logic                  col_valid;
  logic                  col_ready;
  logic [CH_W-1:0]       col_channel;
  logic [IDX_W-1:0]      col_idx;
  logic                  win_valid;
  logic [OCN_W-1:0]      out_col_num;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, data_in, col_ready,
    output rd_en, addr, col_data, col_valid, col_channel, col_idx,
           win_valid, out_col_num, busy, done
  );

  modport slave (
    output start, base_addr, data_in, col_ready,
    input  rd_en, addr, col_data, col_valid, col_channel, col_idx,
           win_valid, out_col_num, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv_column_streamer.sv
`default_nettype none
// Fetches padded image columns from feature-map RAM, channel by channel, and streams them
// one per handshake to the conv array together with stride-aware window flags.
module conv_column_streamer #(
  parameter int DATA_WIDTH   = 16,
  parameter int BUS_WIDTH    = 256,
  parameter int IMAGE_SIZE   = 28,
  parameter int KERNEL_SIZE  = 5,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 0,
  parameter int NUM_CHANNELS = 1,
  parameter int ADDR_WIDTH   = 12
) (
  input  wire logic              clk,
  input  wire logic              rst,
  conv_column_streamer_if.master bus
);
  localparam int PPW   = BUS_WIDTH / DATA_WIDTH;
  localparam int WPC   = (IMAGE_SIZE + PPW - 1) / PPW;
  localparam int PW    = IMAGE_SIZE + 2 * PADDING;
  localparam int CH_W  = $clog2(NUM_CHANNELS) + 1;
  localparam int IDX_W = $clog2(PW) + 1;
  localparam int OCN_W = $clog2(IMAGE_SIZE) + 1;
  localparam int FC_W  = $clog2(WPC + 1) + 1;
  localparam int KM1   = KERNEL_SIZE - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CH_W-1:0]          ch;
  logic [IDX_W-1:0]         c;
  logic [FC_W-1:0]          fcnt;
  logic [ADDR_WIDTH-1:0]    rd_ptr;
  logic [PW*DATA_WIDTH-1:0] col_reg;

  logic             rd_en;
  logic             capture;
  logic             col_valid;
  logic             accept;
  logic             last_col;
  logic             frame_end;
  logic             enter_pad;
  logic             win;
  logic [IDX_W-1:0] c_nx;
  logic [IDX_W-1:0] off;

  function automatic logic is_pad(input logic [IDX_W-1:0] x);
    return (int'(x) < PADDING) || (int'(x) >= PADDING + IMAGE_SIZE);
  endfunction

  assign rd_en     = (state == FETCH) && (fcnt < FC_W'(WPC));
  assign capture   = (state == FETCH) && (fcnt != '0);
  assign col_valid = (state == EMIT);
  assign accept    = col_valid && bus.col_ready;
  assign last_col  = (c == IDX_W'(PW - 1));
  assign frame_end = last_col && (ch == CH_W'(NUM_CHANNELS - 1));
  assign c_nx      = last_col ? '0 : c + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    enter_pad = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_pad('0)) begin
            state_nx  = EMIT;
            enter_pad = 1'b1;
          end else begin
            state_nx = FETCH;
          end
        end
      end
      FETCH: begin
        if (fcnt == FC_W'(WPC)) state_nx = EMIT;
      end
      EMIT: begin
        if (accept) begin
          if (frame_end) begin
            state_nx = DONE;
          end else if (is_pad(c_nx)) begin
            state_nx  = EMIT;
            enter_pad = 1'b1;
          end else begin
            state_nx = FETCH;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Data columns of all channels are stored back to back, so the read address is a running pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch      <= '0;
      c       <= '0;
      fcnt    <= '0;
      rd_ptr  <= '0;
      col_reg <= '0;
    end else begin
      fcnt <= (state == FETCH) ? fcnt + 1'b1 : '0;
      if (state == IDLE && bus.start) begin
        rd_ptr <= bus.base_addr;
        ch     <= '0;
        c      <= '0;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (accept) begin
        c  <= c_nx;
        ch <= frame_end ? '0 : (last_col ? ch + 1'b1 : ch);
      end
      if (enter_pad) col_reg <= '0;
      // Border rows are never written, so they keep the zeros from reset or the last clear.
      if (capture) begin
        for (int r = 0; r < IMAGE_SIZE; r++) begin
          if (r / PPW == int'(fcnt) - 1)
            col_reg[(PADDING + r) * DATA_WIDTH +: DATA_WIDTH] <= bus.data_in[(r % PPW) * DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign off = c - IDX_W'(KM1);
  assign win = col_valid && (int'(c) >= KM1) && ((off % IDX_W'(STRIDE)) == '0);

  assign bus.rd_en       = rd_en;
  assign bus.addr        = rd_ptr;
  assign bus.col_data    = col_reg;
  assign bus.col_valid   = col_valid;
  assign bus.col_channel = ch;
  assign bus.col_idx     = c;
  assign bus.win_valid   = win;
  assign bus.out_col_num = win ? OCN_W'(off / IDX_W'(STRIDE)) : '0;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
endmodule
`default_nettype wire
